n_bit_counter: RTL and testbench
================================

Name: n_bit_counter

Overview:
- Free-running binary up-counter with parameterizable width.
- Advances by one on every rising clock edge, wrapping modulo MAX_COUNT+1.
- Counts edges of a ring-oscillator (or any) clock domain.
- Also provides a terminal-count flag, a sticky overflow flag and a Gray-coded copy of the count for safe sampling from another clock domain.

Parameters:
- WIDTH, 8, bit width of the count outputs; legal range 2..32.
- MAX_COUNT, 2**WIDTH-1, last value before wrap-around; must satisfy RESET_VALUE <= MAX_COUNT <= 2**WIDTH-1.
- RESET_VALUE, 0, value loaded by reset and at power-up; must be <= MAX_COUNT.

Ports:
- clk, input, 1, counting clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- count, output, WIDTH, current binary count, registered.
- count_gray, output, WIDTH, Gray code of count (count ^ (count >> 1)), registered; changes in the same cycle as count.
- tc, output, 1, terminal count; high while count == MAX_COUNT; combinational decode of the count register.
- overflow, output, 1, sticky flag; set on the first wrap MAX_COUNT -> 0; cleared only by reset.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset: while rst_n=0, regardless of clk:
  - count = RESET_VALUE
  - count_gray = gray(RESET_VALUE)
  - overflow = 0
  - tc = (RESET_VALUE == MAX_COUNT)
- Reset assertion takes effect immediately. Deassertion is sampled at the next rising edge; the first increment happens on the first rising edge with rst_n=1.
- Power-up: all state registers carry an initial value equal to their reset value (count = RESET_VALUE, gray = gray(RESET_VALUE), overflow = 0). A bench that never asserts rst_n therefore sees defined values from time 0, not X.
- Counting: on each rising clk edge with rst_n=1:
  - count <= (count == MAX_COUNT) ? 0 : count + 1
  - Latency 1 cycle; no enable; counts every edge.
- Wrap: when count == MAX_COUNT at a rising edge:
  - count becomes 0, not RESET_VALUE.
  - overflow <= 1 on the same edge.
  - tc drops in the same cycle that count becomes 0.
- Gray output:
  - count_gray is registered from gray(next count), so it is always gray(count) with no extra latency.
  - Exactly one bit changes per increment, including the MAX_COUNT -> 0 transition when MAX_COUNT = 2**WIDTH-1.
  - For non-power-of-two moduli the wrap step may change more than one bit; this is allowed.
- Arithmetic: unsigned, WIDTH bits. The increment must never produce a carry into bit WIDTH. No other saturation.
- Reset mid-count: asynchronous return to the reset values. overflow clears even if it was set.
- No other inputs; no X propagation from any reachable state.

Decomposition:
- Package n_bit_counter_pkg:
  - Constant DEFAULT_COUNTER_WIDTH = 8.
  - Function bin2gray(value) returning value ^ (value >> 1), width-generic via WIDTH.
- One sub-module: n_bit_counter_gray_reg. It is the WIDTH-bit register holding the Gray code, with asynchronous active-low reset and a reset value input.
- The top level holds the binary count register, wrap logic, tc decode and the overflow flop.

Test Plan:
- No reset ever asserted (rst_n=1 from t=0), clock idle 100 ns, then 10 rising edges at 20 ns period:
  - count = 0 before the first edge, increments 1..10, ends at 10.
  - count_gray ends at 8'h0F.
  - tc = 0, overflow = 0 throughout.
- rst_n=0 for 3 cycles, then released; 255 edges:
  - count = 255 (8'hFF), tc = 1, overflow = 0.
  - Next edge: count = 0, tc = 0, overflow = 1; count_gray goes 8'h80 -> 8'h00.
- Assert rst_n=0 asynchronously mid-cycle at count = 37 with overflow=1:
  - count = 0 and overflow = 0 immediately, before the next clk edge.
  - After release, the first edge gives count = 1.
- WIDTH=4, MAX_COUNT=9, RESET_VALUE=3:
  - After reset count = 3.
  - Edges give 4..9; tc = 1 at 9.
  - Next edge gives 0 (not 3) and overflow = 1.
- Gray check over a full 256-count sweep (default parameters): every step count_gray == count ^ (count >> 1), and the Hamming distance between successive count_gray values is exactly 1.
- Hold rst_n=0 while toggling clk 20 times: count stays at RESET_VALUE, and count_gray and overflow stay at their reset values.

Source files
------------

// File: rtl/n_bit_counter_pkg.sv
// Shared constants and helpers for the free-running n_bit_counter.
package n_bit_counter_pkg;

  localparam int DEFAULT_COUNTER_WIDTH = 8;

  // Callers size-cast the result to their own WIDTH.
  function automatic logic [31:0] bin2gray(input logic [31:0] value);
    return value ^ (value >> 1);
  endfunction

endpackage

// File: rtl/n_bit_counter_gray_reg.sv
// WIDTH-bit register holding the Gray-coded copy of the count.
module n_bit_counter_gray_reg #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] reset_value_i,
  input  logic [WIDTH-1:0] gray_d_i,
  output logic [WIDTH-1:0] gray_o
);

  // Power-up value matches the reset value, so the output is never X.
  logic [WIDTH-1:0] gray_q = INIT_VALUE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gray_q <= reset_value_i;
    else        gray_q <= gray_d_i;
  end

  assign gray_o = gray_q;

endmodule

// File: rtl/n_bit_counter.sv
// Free-running modulo-(MAX_COUNT+1) up-counter with terminal-count,
// sticky overflow and a registered Gray-coded copy of the count.
module n_bit_counter
  import n_bit_counter_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_COUNTER_WIDTH,
  parameter logic [WIDTH-1:0] MAX_COUNT   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_gray,
  output logic             tc,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] RESET_GRAY = WIDTH'(bin2gray(32'(RESET_VALUE)));

  logic [WIDTH-1:0] count_q = RESET_VALUE;
  logic             overflow_q = 1'b0;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] gray_d;
  logic             wrap;

  // Wrap goes to zero, not RESET_VALUE; the compare keeps the add carry-free.
  assign wrap    = (count_q == MAX_COUNT);
  assign count_d = wrap ? '0 : count_q + WIDTH'(1);
  assign gray_d  = WIDTH'(bin2gray(32'(count_d)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= RESET_VALUE;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_q | wrap;
    end
  end

  n_bit_counter_gray_reg #(
    .WIDTH     (WIDTH),
    .INIT_VALUE(RESET_GRAY)
  ) u_gray_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .reset_value_i(RESET_GRAY),
    .gray_d_i     (gray_d),
    .gray_o       (count_gray)
  );

  assign count    = count_q;
  assign tc       = wrap;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_n_bit_counter.sv
// Directed self-checking bench for n_bit_counter (default and 4-bit mod-10 builds).
module tb_n_bit_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rst4_n = 1'b1;
  logic [7:0] count, countGray;
  logic       tc, overflow;
  logic [3:0] count4, countGray4;
  logic       tc4, overflow4;
  int         testsRun = 0;
  int         testsFailed = 0;

  n_bit_counter dut (
    .clk(clk), .rst_n(rst_n), .count(count), .count_gray(countGray),
    .tc(tc), .overflow(overflow)
  );

  n_bit_counter #(.WIDTH(4), .MAX_COUNT(4'd9), .RESET_VALUE(4'd3)) dut4 (
    .clk(clk), .rst_n(rst4_n), .count(count4), .count_gray(countGray4),
    .tc(tc4), .overflow(overflow4)
  );

  // One full clock period; outputs are checked afterwards at the falling edge.
  task automatic cycle();
    #10 clk = 1'b1;
    #10 clk = 1'b0;
  endtask

  task automatic test_powerup();
    logic [7:0] expGray;
    #1;
    testsRun++;
    if (count !== 8'd0 || overflow !== 1'b0 || tc !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL powerup: count=%h tc=%b ovf=%b, want 00 0 0", count, tc, overflow);
    end
    testsRun++;
    if (count4 !== 4'd3 || countGray4 !== 4'h2 || overflow4 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL powerup4: count=%h gray=%h ovf=%b, want 3 2 0", count4, countGray4, overflow4);
    end
    #99;
    testsRun++;
    if (count !== 8'd0) begin
      testsFailed++;
      $display("[TB] FAIL idle: count=%h, want 00", count);
    end
    for (int i = 1; i <= 10; i++) begin
      cycle();
      expGray = 8'(i) ^ (8'(i) >> 1);
      testsRun++;
      if (count !== 8'(i) || countGray !== expGray || tc !== 1'b0 || overflow !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL noreset_count: count=%h gray=%h tc=%b ovf=%b, want %h %h 0 0",
                 count, countGray, tc, overflow, 8'(i), expGray);
      end
    end
    testsRun++;
    if (countGray !== 8'h0F) begin
      testsFailed++;
      $display("[TB] FAIL noreset_gray: gray=%h, want 0f", countGray);
    end
  endtask

  task automatic test_reset_and_wrap();
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (count !== 8'd0 || countGray !== 8'd0 || overflow !== 1'b0 || tc !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_async: count=%h gray=%h ovf=%b tc=%b, want 00 00 0 0",
               count, countGray, overflow, tc);
    end
    #19 clk = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (255) cycle();
    testsRun++;
    if (count !== 8'hFF || tc !== 1'b1 || overflow !== 1'b0 || countGray !== 8'h80) begin
      testsFailed++;
      $display("[TB] FAIL at_max: count=%h tc=%b ovf=%b gray=%h, want ff 1 0 80",
               count, tc, overflow, countGray);
    end
    cycle();
    testsRun++;
    if (count !== 8'h00 || tc !== 1'b0 || overflow !== 1'b1 || countGray !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL wrap: count=%h tc=%b ovf=%b gray=%h, want 00 0 1 00",
               count, tc, overflow, countGray);
    end
  endtask

  task automatic test_midcycle_reset();
    repeat (37) cycle();
    testsRun++;
    if (count !== 8'd37 || overflow !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL pre_midreset: count=%0d ovf=%b, want 37 1", count, overflow);
    end
    #5 rst_n = 1'b0;
    #1;
    testsRun++;
    if (count !== 8'd0 || overflow !== 1'b0 || countGray !== 8'd0) begin
      testsFailed++;
      $display("[TB] FAIL midreset: count=%0d ovf=%b gray=%h, want 0 0 00", count, overflow, countGray);
    end
    #4;
    cycle();
    rst_n = 1'b1;
    cycle();
    testsRun++;
    if (count !== 8'd1 || countGray !== 8'd1) begin
      testsFailed++;
      $display("[TB] FAIL after_release: count=%0d gray=%h, want 1 01", count, countGray);
    end
  endtask

  task automatic test_modulo10();
    logic [3:0] expGray;
    rst4_n = 1'b0;
    #1;
    testsRun++;
    if (count4 !== 4'd3 || countGray4 !== 4'h2 || tc4 !== 1'b0 || overflow4 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL mod10_reset: count=%0d gray=%h tc=%b ovf=%b, want 3 2 0 0",
               count4, countGray4, tc4, overflow4);
    end
    #9;
    cycle();
    rst4_n = 1'b1;
    for (int i = 4; i <= 9; i++) begin
      cycle();
      expGray = 4'(i) ^ (4'(i) >> 1);
      testsRun++;
      if (count4 !== 4'(i) || countGray4 !== expGray || tc4 !== (i == 9) || overflow4 !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL mod10_count: count=%0d gray=%h tc=%b ovf=%b, want %0d %h %b 0",
                 count4, countGray4, tc4, overflow4, i, expGray, (i == 9));
      end
    end
    cycle();
    testsRun++;
    if (count4 !== 4'd0 || countGray4 !== 4'd0 || tc4 !== 1'b0 || overflow4 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL mod10_wrap: count=%0d gray=%h tc=%b ovf=%b, want 0 0 0 1",
               count4, countGray4, tc4, overflow4);
    end
  endtask

  task automatic test_gray_sweep();
    logic [7:0] expCount, expGray, prevGray;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    expCount = 8'd0;
    prevGray = 8'd0;
    for (int i = 0; i < 256; i++) begin
      cycle();
      expCount = expCount + 8'd1;
      expGray = expCount ^ (expCount >> 1);
      testsRun++;
      if (count !== expCount || countGray !== expGray || $countones(countGray ^ prevGray) != 1) begin
        testsFailed++;
        $display("[TB] FAIL gray_sweep: count=%h gray=%h prev=%h, want %h %h one-bit step",
                 count, countGray, prevGray, expCount, expGray);
      end
      prevGray = countGray;
    end
  endtask

  task automatic test_hold_reset();
    rst_n = 1'b0;
    rst4_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      testsRun++;
      if (count !== 8'd0 || countGray !== 8'd0 || overflow !== 1'b0 ||
          count4 !== 4'd3 || countGray4 !== 4'h2 || overflow4 !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL hold_reset: count=%h gray=%h ovf=%b count4=%h gray4=%h ovf4=%b, want 00 00 0 3 2 0",
                 count, countGray, overflow, count4, countGray4, overflow4);
      end
    end
    rst_n = 1'b1;
    rst4_n = 1'b1;
  endtask

  initial begin
    test_powerup();
    test_reset_and_wrap();
    test_midcycle_reset();
    test_modulo10();
    test_gray_sweep();
    test_hold_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
